// File: rtl/clock_pkg.sv
// Shared constants and types for the clock-setting front end.
// Tick constants assume the system-wide 2 ms enable tick.
package clock_pkg;

  localparam int unsigned TICK_MS         = 2;
  localparam int unsigned DEB_TICKS       = 10  / TICK_MS;
  localparam int unsigned REP_DELAY_TICKS = 500 / TICK_MS;
  localparam int unsigned REP_RATE_TICKS  = 100 / TICK_MS;

  // Five-button vector consumed by the clock controller
  typedef logic [4:0] btn_vec_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bus between board inputs and the debouncer.
// The master drives tick and raw buttons; the slave (debouncer) returns levels and pulses.
interface btn_debounce_multi_if #(
  parameter int unsigned N_CH = 4
);

  logic            i_ena;
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;

  modport master (
    output i_ena, i_btn,
    input  o_level, o_press, o_release
  );

  modport slave (
    input  i_ena, i_btn,
    output o_level, o_press, o_release
  );

endinterface

// File: rtl/btn_debounce_chan.sv
// Single-channel debouncer: 2-flop synchroniser, tick-driven stability filter, edge pulses.
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_chan
  import clock_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEB_TICKS,
  parameter int unsigned REPEAT_DELAY = REP_DELAY_TICKS,
  parameter int unsigned REPEAT_RATE  = REP_RATE_TICKS
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ena,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned          CNT_W    = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0]     CNT_TERM = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_debounce_chan: illegal parameter combination");
  end

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned       RCNT_W    = $clog2(REPEAT_DELAY + 1);
  localparam logic [RCNT_W-1:0] RC_TERM   = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RC_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [RCNT_W-1:0] RC_ONE    = RCNT_W'(1);

  logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
  assign rcnt_inc = rcnt_q + RC_ONE;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rcnt_d    = rcnt_q;
`endif
    if (i_ena) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_TERM) begin
        cnt_d     = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
`ifdef BTN_AUTOREPEAT_EN
      // A falling edge on this tick wins over a due repeat, so press/release stay exclusive
      if (level_q && !level_d) begin
        rcnt_d = '0;
      end else if (level_q) begin
        if (rcnt_inc == RC_TERM) begin
          press_d = 1'b1;
          rcnt_d  = RC_RELOAD;
        end else begin
          rcnt_d  = rcnt_inc;
        end
      end
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      sync1_q   <= i_btn;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer sharing one enable tick; one btn_debounce_chan per button.
// Optional hold-to-repeat selected by defining BTN_AUTOREPEAT_EN.
module btn_debounce_multi
  import clock_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned STABLE_TICKS = DEB_TICKS,
  parameter int unsigned REPEAT_DELAY = REP_DELAY_TICKS,
  parameter int unsigned REPEAT_RATE  = REP_RATE_TICKS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  btn_debounce_multi_if.slave  bus
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_p;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    btn_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_ena     (bus.i_ena),
      .i_btn     (bus.i_btn[g]),
      .o_level   (level[g]),
      .o_press   (press[g]),
      .o_release (release_p[g])
    );
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = release_p;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random buttons against a window-based model.
// Repeat expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_btn_debounce_multi;

  localparam int unsigned N = 4;
  localparam int unsigned K = 5;
  localparam int unsigned D = 8;
  localparam int unsigned R = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   act1   = 0;
  int   div    = 1;
  int   ph     = 0;

  btn_debounce_multi_if #(.N_CH(N)) bus ();

  btn_debounce_multi #(
    .N_CH         (N),
    .STABLE_TICKS (K),
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: level flips once the last K tick samples of the synchronised input all differ from it
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_release = '0;
  logic [K-1:0] m_win  [N];
  int           m_fill [N];
  int           m_held [N];

  initial begin
    for (int c = 0; c < N; c++) begin m_win[c] = '0; m_fill[c] = 0; m_held[c] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
        for (int c = 0; c < N; c++) begin m_win[c] = '0; m_fill[c] = 0; m_held[c] = 0; end
      end else begin
        m_press   = '0;
        m_release = '0;
        if (bus.i_ena) begin
          for (int c = 0; c < N; c++) begin
            m_win[c] = {m_win[c][K-2:0], m_s2[c]};
            if (m_fill[c] < K) m_fill[c]++;
            if (m_fill[c] == K && m_win[c] == {K{~m_level[c]}}) begin
              m_level[c]   = ~m_level[c];
              m_press[c]   = m_level[c];
              m_release[c] = ~m_level[c];
              m_held[c]    = 0;
            end else if (m_level[c]) begin
              m_held[c]++;
`ifdef BTN_AUTOREPEAT_EN
              if (m_held[c] >= D && (m_held[c] - D) % R == 0) m_press[c] = 1'b1;
`endif
            end
          end
        end
        m_s2 = m_s1;
        m_s1 = bus.i_btn;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      assert (bus.o_level === m_level) else begin
        errors++; $error("FAIL level obs=%b exp=%b t=%0t", bus.o_level, m_level, $time);
      end
      checks++;
      assert (bus.o_press === m_press) else begin
        errors++; $error("FAIL press obs=%b exp=%b t=%0t", bus.o_press, m_press, $time);
      end
      checks++;
      assert (bus.o_release === m_release) else begin
        errors++; $error("FAIL release obs=%b exp=%b t=%0t", bus.o_release, m_release, $time);
      end
      checks++;
      assert ((bus.o_press & bus.o_release) === '0) else begin
        errors++; $error("FAIL excl obs=%b exp=0 t=%0t", bus.o_press & bus.o_release, $time);
      end
      if (bus.o_level[1] || bus.o_press[1] || bus.o_release[1]) act1++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      ph++;
      bus.i_ena = (ph % div == 0);
    end
  endtask

  initial begin
    int lat, n, a0, hold[N];
    logic e, ar, exp_p;
`ifdef BTN_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    rst_n     = 1'b0;
    bus.i_btn = '0;
    bus.i_ena = 1'b1;
    cyc(3);
    chk("rst_level",   bus.o_level,   0);
    chk("rst_press",   bus.o_press,   0);
    chk("rst_release", bus.o_release, 0);
    rst_n = 1'b1;
    cyc(2);

    // Clean press on channel 0 with the tick tied high
    bus.i_btn[0] = 1'b1;
    cyc(6);
    chk("t1_lvl_c6", bus.o_level[0], 0);
    cyc(1);
    chk("t1_lvl_c7",   bus.o_level[0],     1);
    chk("t1_prs_c7",   bus.o_press[0],     1);
    chk("t1_other_lv", bus.o_level[3:1],   0);
    chk("t1_other_pr", bus.o_press[3:1],   0);
    cyc(1);
    chk("t1_prs_c8",   bus.o_press[0],     0);

    // Four-tick glitches on channel 1 must never reach the output
    a0 = act1;
    for (int i = 0; i < 10; i++) begin
      bus.i_btn[1] = 1'b1; cyc(4);
      bus.i_btn[1] = 1'b0; cyc(1);
    end
    cyc(8);
    chk("t2_glitch", act1 - a0, 0);

    // Clean release on channel 2
    bus.i_btn[2] = 1'b1;
    cyc(12);
    bus.i_btn[2] = 1'b0;
    cyc(6);
    chk("t3_rel_c6", bus.o_release[2], 0);
    cyc(1);
    chk("t3_rel_c7", bus.o_release[2], 1);
    chk("t3_prs_c7", bus.o_press[2],   0);
    chk("t3_lvl_c7", bus.o_level[2],   0);
    cyc(1);
    chk("t3_rel_c8", bus.o_release[2], 0);

    // Tick every 4th cycle on channel 3
    div = 4;
    bus.i_btn[3] = 1'b1;
    lat = 0;
    while (bus.o_level[3] !== 1'b1 && lat < 40) begin cyc(1); lat++; end
    chk("t4_lat_ok", lat <= 23, 1);
    bus.i_btn[3] = 1'b0;
    lat = 0;
    while (bus.o_level[3] !== 1'b0 && lat < 40) begin cyc(1); lat++; end
    chk("t4_fall", bus.o_level[3], 0);
    bus.i_btn[3] = 1'b1;
    cyc(2);
    n = 0;
    while (n < 3) begin e = bus.i_ena; cyc(1); if (e) n++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_lvl", bus.o_level,   0);
    chk("t4_rst_prs", bus.o_press,   0);
    chk("t4_rst_rel", bus.o_release, 0);
    cyc(3);
    div = 1;
    bus.i_ena = 1'b1;
    rst_n = 1'b1;
    cyc(6);
    chk("t4_held_c6", bus.o_level[3], 0);
    cyc(1);
    chk("t4_held_lv", bus.o_level[3], 1);
    chk("t4_held_pr", bus.o_press[3], 1);

    // Long hold on channel 2: repeats only when the feature is built
    bus.i_btn = '0;
    cyc(15);
    bus.i_btn[2] = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      exp_p = (i == 7) || (ar && i >= 15 && (i - 15) % 3 == 0);
      chk($sformatf("t5_hold_%0d", i), bus.o_press[2], exp_p);
    end
    bus.i_btn[2] = 1'b0;
    cyc(7);
    chk("t5_fell", bus.o_level[2], 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("t5_after", bus.o_press[2], 0);
    end

    // Random buttons and tick spacing, checked by the model every cycle
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 30);
    for (int t = 0; t < 2400; t++) begin
      if (t % 60 == 0) div = $urandom_range(1, 3);
      if (t == 1200) begin
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          bus.i_btn[c] = ~bus.i_btn[c];
          hold[c] = $urandom_range(1, 30);
        end
      end
      cyc(1);
    end

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

- Parametrised N-channel push-button debouncer.
- Each channel has a two-flop synchroniser and a counter-based stability filter.
- Each channel produces a debounced level plus single-cycle press and release pulses; optional hold-to-repeat.
- Sits between the board push-buttons and the clock-setting control logic.
- Replaces per-button shift-register debouncers; shares the system 2 ms enable tick.

## Interface
- `N_CH`, 4, number of independent button channels.
- `STABLE_TICKS`, 5, consecutive `i_ena` ticks a new input value must hold before `o_level` follows it (5 × 2 ms = 10 ms); legal range 1..255.
- `REPEAT_DELAY`, 250, ticks of continuous hold before the first repeat press (500 ms); used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_RATE`, 50, ticks between subsequent repeat presses (100 ms); used only with `BTN_AUTOREPEAT_EN`.

Ports:
- `i_clk`  in  1  system clock; the single clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_ena`  in  1  sample tick, one `i_clk` cycle wide; may be tied high.
- `i_btn`  in  N_CH  raw asynchronous buttons, active-high (1 = pressed).
- `o_level`  out  N_CH  debounced level per channel.
- `o_press`  out  N_CH  one-cycle pulse per rising debounced edge, and per repeat event.
- `o_release`  out  N_CH  one-cycle pulse per falling debounced edge.

## Operation
- Synchroniser: two flops per channel, clocked every `i_clk` and not gated by `i_ena`. Output `sync[i]`.
- Filter, evaluated only on cycles with `i_ena`=1:
  - `sync[i]` == `o_level[i]`: clear `cnt[i]`.
  - `sync[i]` != `o_level[i]` and `cnt[i]` == `STABLE_TICKS`-1: toggle `o_level[i]` and clear `cnt[i]`.
  - Otherwise: increment `cnt[i]`.
- Consequence: any glitch shorter than `STABLE_TICKS` ticks restarts the count and never reaches `o_level`.
- `cnt` width is `$clog2(STABLE_TICKS)`, minimum 1. It never wraps, because it clears at the terminal value.
- `STABLE_TICKS`=1: level follows `sync` on the first differing tick.
- Edge outputs, registered:
  - `o_press[i]` = 1 for exactly one `i_clk` cycle, the first cycle `o_level[i]` reads 1.
  - `o_release[i]` = 1 for exactly one `i_clk` cycle, the first cycle `o_level[i]` reads 0.
- Channels are fully independent. Simultaneous edges on several channels give simultaneous pulses.
- `o_press` and `o_release` are never both high on one channel.

## Timing
- Reset values: `sync`, `cnt`, `o_level`, `o_press`, `o_release`, repeat counter all 0.
- Reset asserted mid-count or mid-hold: everything clears and no pulse is emitted.
- After reset release, a button already held produces a normal `o_press` once debounced.
- Press latency, from stable `i_btn` change to `o_level`/`o_press`:
  - 2 `i_clk` (synchroniser), plus
  - wait to the next `i_ena` tick, plus
  - `STABLE_TICKS`-1 further ticks, plus
  - 1 `i_clk` (register).
- With `i_ena` tied high: latency is exactly `STABLE_TICKS`+2 cycles.
- Input changing between ticks is sampled only at ticks.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - Per-channel repeat counter `rcnt`, width `$clog2(REPEAT_DELAY+1)`.
  - While `o_level[i]`=1, `rcnt` counts `i_ena` ticks.
  - On reaching `REPEAT_DELAY`: pulse `o_press[i]` and reload `rcnt` to `REPEAT_DELAY`-`REPEAT_RATE`.
  - Repeats therefore continue every `REPEAT_RATE` ticks.
  - `rcnt` clears on any release or reset.
  - Requirement: `REPEAT_RATE` ≤ `REPEAT_DELAY`.
- `BTN_AUTOREPEAT_EN` not defined:
  - No repeat counter is synthesised.
  - `o_press` fires only on debounced rising edges.
  - `REPEAT_*` parameters are ignored.

## Structure
- Shared package `clock_pkg` holds:
  - `TICK_MS` (2);
  - default debounce, repeat-delay and repeat-rate tick constants;
  - typedef `btn_vec_t` for the 5-button vector used by the clock controller.
- One sub-module, `btn_debounce_chan`: synchroniser, filter, edge and repeat logic for a single channel.
  - The top is a `generate` loop of `N_CH` instances.

## Test plan
1. Reset, `i_ena`=1, `STABLE_TICKS`=5, `i_btn[0]` 0→1 and held → `o_level[0]` rises at cycle 7, `o_press[0]` high only in cycle 7, other channels stay 0.
2. `i_btn[1]` pulses high for 4 ticks, 10 times, at 1-tick gaps → `o_level[1]`, `o_press[1]`, `o_release[1]` stay 0 throughout.
3. Held channel 2 released cleanly → one `o_release[2]` pulse exactly 7 cycles after the fall; no `o_press`.
4. `i_ena` every 4th cycle, `i_btn[3]` pressed → level rises after 5 ticks, within 2+20+1 cycles; `i_rst_n` low at tick 3 of a second press → outputs 0 immediately, no pulse.
5. `BTN_AUTOREPEAT_EN` defined, `REPEAT_DELAY`=8, `REPEAT_RATE`=3, `i_ena`=1, hold 30 ticks → `o_press` at the edge, then 8, 11, 14, … ticks later; release → no further presses.
